instr_fetch: RTL and testbench



---
 rtl/instr_fetch.sv | 124 ++++++++++++
 tb/tb_instr_fetch.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, keeps one imem read in flight and
// buffers returned words in a 2-entry prefetch queue for decode.
module instr_fetch #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_re,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_vld,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_tgt,
  input  logic        hlt
);

  localparam int unsigned W = 16;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP, S_HALT} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   pc_q, pc_d;
  logic [W-1:0]   req_pc_q, req_pc_d;
  logic [W-1:0]   q_data_q [2];
  logic [W-1:0]   q_data_d [2];
  logic [W-1:0]   q_pc_q   [2];
  logic [W-1:0]   q_pc_d   [2];
  logic [1:0]     cnt_q, cnt_d, cnt_pop;
  logic           pop, push, issue;
  logic           re_d, vld_d;
  logic [W-1:0]   addr_d, instr_d, instr_pc_d;

  // Next-state, queue update and request issue; entry 0 is the queue head.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    q_data_d  = q_data_q;
    q_pc_d    = q_pc_q;
    cnt_d     = cnt_q;
    cnt_pop   = cnt_q;
    pop       = 1'b0;
    push      = 1'b0;
    issue     = 1'b0;
    re_d      = 1'b0;
    addr_d    = imem_addr;

    if (state_q != S_HALT) begin
      if (hlt) begin
        state_d = S_HALT;
      end else if (br_taken) begin
        cnt_d = 2'd0;
        pc_d  = br_tgt;
        if (state_q != S_IDLE) begin
          state_d = imem_rdy ? S_IDLE : S_DROP;
        end
      end else begin
        pop     = (cnt_q != 2'd0) && !stall;
        push    = (state_q == S_WAIT) && imem_rdy;
        cnt_pop = cnt_q - 2'(pop);
        if (pop) begin
          q_data_d[0] = q_data_q[1];
          q_pc_d[0]   = q_pc_q[1];
        end
        if (push) begin
          q_data_d[cnt_pop[0]] = imem_data;
          q_pc_d[cnt_pop[0]]   = req_pc_q;
        end
        cnt_d = cnt_pop + 2'(push);
        if (state_q != S_IDLE && imem_rdy) begin
          state_d = S_IDLE;
        end
        // A dropped response returns to IDLE without issuing in the same cycle.
        issue = ((state_q == S_IDLE) || push) && (cnt_d < 2'd2);
        if (issue) begin
          re_d     = 1'b1;
          addr_d   = pc_q;
          req_pc_d = pc_q;
          pc_d     = pc_q + W'(1);
          state_d  = S_WAIT;
        end
      end
    end

    vld_d      = (cnt_d != 2'd0) && (state_d != S_HALT);
    instr_d    = vld_d ? q_data_d[0] : NOP_INSTR;
    instr_pc_d = vld_d ? q_pc_d[0]   : '0;
  end

  // State, queue storage and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      req_pc_q  <= '0;
      q_data_q  <= '{default: '0};
      q_pc_q    <= '{default: '0};
      cnt_q     <= 2'd0;
      imem_re   <= 1'b0;
      imem_addr <= '0;
      instr     <= NOP_INSTR;
      instr_pc  <= '0;
      instr_vld <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_pc_q  <= req_pc_d;
      q_data_q  <= q_data_d;
      q_pc_q    <= q_pc_d;
      cnt_q     <= cnt_d;
      imem_re   <= re_d;
      imem_addr <= addr_d;
      instr     <= instr_d;
      instr_pc  <= instr_pc_d;
      instr_vld <= vld_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: randomized memory latency, stall and redirects, checked
// against an address-stream model through an expected-instruction queue.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_re, imem_rdy;
  logic [15:0] imem_addr, imem_data;
  logic [15:0] instr, instr_pc;
  logic        instr_vld;
  logic        stall, br_taken, hlt;
  logic [15:0] br_tgt;

  logic        w_re, w_rdy, w_vld;
  logic [15:0] w_addr, w_data, w_instr, w_instr_pc;

  int n_checks = 0;
  int n_fail   = 0;
  int re_cnt   = 0;
  int deliv_cnt = 0;

  always #5 clk = ~clk;

  instr_fetch u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_re(imem_re), .imem_addr(imem_addr), .imem_rdy(imem_rdy), .imem_data(imem_data),
    .instr(instr), .instr_pc(instr_pc), .instr_vld(instr_vld),
    .stall(stall), .br_taken(br_taken), .br_tgt(br_tgt), .hlt(hlt)
  );

  instr_fetch #(.RESET_PC(16'hFFFF), .NOP_INSTR(16'h0000)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_re(w_re), .imem_addr(w_addr), .imem_rdy(w_rdy), .imem_data(w_data),
    .instr(w_instr), .instr_pc(w_instr_pc), .instr_vld(w_vld),
    .stall(1'b0), .br_taken(1'b0), .br_tgt(16'h0000), .hlt(1'b0)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a + 16'h1000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Main memory: responds (mem_lat+1) cycles after seeing a request.
  int          mem_lat = 0;
  logic        mem_pending = 1'b0;
  int          mem_cnt = 0;
  logic [15:0] mem_addr = '0;
  always @(posedge clk) begin
    imem_rdy <= 1'b0;
    if (mem_pending) begin
      if (mem_cnt == 0) begin
        imem_rdy    <= 1'b1;
        imem_data   <= mem_word(mem_addr);
        mem_pending <= 1'b0;
      end else begin
        mem_cnt <= mem_cnt - 1;
      end
    end
    if (imem_re) begin
      if (mem_lat == 0) begin
        imem_rdy  <= 1'b1;
        imem_data <= mem_word(imem_addr);
      end else begin
        mem_pending <= 1'b1;
        mem_cnt     <= mem_lat - 1;
        mem_addr    <= imem_addr;
      end
    end
  end

  // Wrap instance memory: fixed 1-cycle latency.
  always @(posedge clk) begin
    w_rdy  <= w_re;
    w_data <= mem_word(w_addr);
  end

  // Reference model: fetch addresses and delivered PCs both run sequentially
  // from the last reset/redirect target; halt freezes everything.
  logic        rst_seen  = 1'b1;
  logic        halted    = 1'b0;
  logic [15:0] fetch_exp = 16'h0000;
  logic [15:0] exp_q [$];
  logic [15:0] w_fetch_exp = 16'hFFFF;
  logic [15:0] w_pc_exp    = 16'hFFFF;

  task automatic restart_stream(input logic [15:0] start);
    exp_q.delete();
    exp_q.push_back(start);
    exp_q.push_back(start + 16'd1);
  endtask

  initial restart_stream(16'h0000);

  always @(negedge clk) begin
    if (rst_seen) begin
      check("rst_imem_re", 32'(imem_re), 32'd0);
      check("rst_imem_addr", 32'(imem_addr), 32'd0);
      check("rst_instr_vld", 32'(instr_vld), 32'd0);
      check("rst_instr", 32'(instr), 32'h0000);
      check("rst_instr_pc", 32'(instr_pc), 32'd0);
    end else begin
      if (halted) begin
        check("halt_imem_re", 32'(imem_re), 32'd0);
        check("halt_instr_vld", 32'(instr_vld), 32'd0);
      end else begin
        if (imem_re) begin
          check("fetch_addr", 32'(imem_addr), 32'(fetch_exp));
          fetch_exp = fetch_exp + 16'd1;
          re_cnt++;
        end
        if (instr_vld) begin
          check("head_pc", 32'(instr_pc), 32'(exp_q[0]));
          check("head_instr", 32'(instr), 32'(mem_word(exp_q[0])));
          if (!stall && !br_taken && !hlt) begin
            void'(exp_q.pop_front());
            if (exp_q.size() < 2) exp_q.push_back(exp_q[exp_q.size()-1] + 16'd1);
            deliv_cnt++;
          end
        end else begin
          check("empty_instr", 32'(instr), 32'h0000);
          check("empty_instr_pc", 32'(instr_pc), 32'd0);
        end
      end
      if (w_re) begin
        check("wrap_fetch_addr", 32'(w_addr), 32'(w_fetch_exp));
        w_fetch_exp = w_fetch_exp + 16'd1;
      end
      if (w_vld) begin
        check("wrap_instr_pc", 32'(w_instr_pc), 32'(w_pc_exp));
        check("wrap_instr", 32'(w_instr), 32'(mem_word(w_pc_exp)));
        w_pc_exp = w_pc_exp + 16'd1;
      end
    end
    // Advance the model with the inputs the next edge will sample.
    if (!rst_n) begin
      halted      = 1'b0;
      fetch_exp   = 16'h0000;
      restart_stream(16'h0000);
      w_fetch_exp = 16'hFFFF;
      w_pc_exp    = 16'hFFFF;
    end else if (!halted) begin
      if (hlt) begin
        halted = 1'b1;
      end else if (br_taken) begin
        fetch_exp = br_tgt;
        restart_stream(br_tgt);
      end
    end
    rst_seen = !rst_n;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (6) tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_re();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      seen = imem_re;
    end
    if (!seen) check("wait_imem_re_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_vld();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      seen = instr_vld;
    end
    if (!seen) check("wait_instr_vld_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int d0, r0;
    rst_n = 1'b0; stall = 1'b0; br_taken = 1'b0; br_tgt = '0; hlt = 1'b0;

    // Free run with a 1-cycle memory.
    do_reset();
    d0 = deliv_cnt;
    repeat (30) tick();
    check("freerun_throughput", 32'(deliv_cnt - d0 >= 12), 32'd1);

    // Stall from reset: exactly two requests fill the queue.
    stall = 1'b1;
    do_reset();
    r0 = re_cnt;
    repeat (10) tick();
    check("stall_req_count", 32'(re_cnt - r0), 32'd2);
    check("stall_head_vld", 32'(instr_vld), 32'd1);
    check("stall_head_pc", 32'(instr_pc), 32'd0);
    stall = 1'b0;
    d0 = deliv_cnt;
    repeat (8) tick();
    check("stall_release_deliv", 32'(deliv_cnt - d0 >= 3), 32'd1);

    // Redirect while a request is outstanding; response lands two cycles later.
    mem_lat = 1;
    wait_re();
    br_taken = 1'b1; br_tgt = 16'h0040;
    tick();
    br_taken = 1'b0;
    wait_re();
    check("redirect_addr", 32'(imem_addr), 32'h0040);
    wait_vld();
    check("redirect_first_pc", 32'(instr_pc), 32'h0040);

    // Reset mid-WAIT; the late response lands on the first post-reset edge.
    wait_re();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    wait_re();
    check("post_reset_addr", 32'(imem_addr), 32'h0000);
    wait_vld();
    check("post_reset_pc", 32'(instr_pc), 32'h0000);
    check("post_reset_instr", 32'(instr), 32'h1000);

    // Randomized stall, latency and redirects.
    for (int i = 0; i < 400; i++) begin
      stall   = ($urandom_range(0, 9) < 3);
      mem_lat = $urandom_range(0, 3);
      if ($urandom_range(0, 24) == 0) begin
        br_taken = 1'b1;
        br_tgt   = $urandom_range(0, 1) ? 16'($urandom) : 16'(32'hFFFD + $urandom_range(0, 2));
      end else begin
        br_taken = 1'b0;
      end
      tick();
    end
    br_taken = 1'b0; stall = 1'b0; mem_lat = 0;
    repeat (10) tick();

    // Halt together with a redirect: halt wins and everything stays quiet.
    hlt = 1'b1; br_taken = 1'b1; br_tgt = 16'h1234;
    tick();
    hlt = 1'b0; br_taken = 1'b0;
    r0 = re_cnt;
    repeat (20) begin
      tick();
      check("halt_vld_low", 32'(instr_vld), 32'd0);
    end
    check("halt_no_requests", 32'(re_cnt - r0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
